// File: rtl/fir_lane_serializer.sv
// rtl/fir_lane_serializer.sv - buffers L-lane FIR output groups and emits them as one sample stream
module fir_lane_serializer #(
    parameter int L     = 3,
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic [W-1:0]                 in_y [0:L-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_y,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         overflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH + 1);
    localparam int LNW = (L > 1) ? $clog2(L) : 1;
    localparam logic [LNW-1:0] LAST_LANE = LNW'(L - 1);
    localparam logic [LVW-1:0] DEPTH_LV  = LVW'(DEPTH);

    logic [W-1:0]   mem [0:DEPTH-1][0:L-1];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [LVW-1:0] cnt;
    logic [LNW-1:0] lane;
    logic           ovf;

    logic xfer;
    logic pop;
    logic push;
    logic drop;

    // Handshake decode; a full FIFO still accepts a group when the head's last lane leaves on the same edge
    always_comb begin
        out_valid = (cnt != '0);
        full      = (cnt == DEPTH_LV);
        xfer      = out_valid && out_ready;
        pop       = xfer && (lane == LAST_LANE);
        push      = in_valid && (!full || pop);
        drop      = in_valid && !push;
        out_y     = out_valid ? mem[rptr][lane] : '0;
        out_last  = out_valid && (lane == LAST_LANE);
    end

    assign level    = cnt;
    assign overflow = ovf;

    // Group storage; contents need no reset because level gates every read
    always_ff @(posedge clk) begin
        if (push && !clr && !rst) begin
            for (int i = 0; i < L; i++) begin
                mem[wptr][i] <= in_y[i];
            end
        end
    end

    // Pointers, occupancy, lane position and sticky drop flag; clr outranks push and transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            lane <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            lane <= '0;
            ovf  <= 1'b0;
        end else begin
            if (xfer) begin
                lane <= pop ? '0 : lane + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_lane_serializer.sv
// tb/tb_fir_lane_serializer.sv - scoreboard bench for fir_lane_serializer
module tb_fir_lane_serializer;

    localparam int L     = 3;
    localparam int DEPTH = 4;
    localparam int W     = 32;
    localparam int LVW   = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_y [0:L-1];
    logic           out_valid;
    logic [W-1:0]   out_y;
    logic           out_last;
    logic [LVW-1:0] level;
    logic           full;
    logic           overflow;

    typedef struct {
        logic [W-1:0] d;
        bit           last;
    } samp_t;

    samp_t exp_q[$];
    int    occ = 0;
    bit    ovf = 1'b0;
    int    compared = 0;
    int    mismatched = 0;

    int m_groups;
    int m_rem;
    bit m_xf;
    bit m_pop;
    bit m_acc;
    int mon_groups;

    fir_lane_serializer #(.L(L), .DEPTH(DEPTH), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .in_valid(in_valid),
        .in_y(in_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .out_last(out_last),
        .level(level),
        .full(full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference model: FIFO of samples; decides the effect of the coming edge from the inputs
    always begin
        @(negedge clk);
        #1;
        if (rst || clr) begin
            occ = 0;
            ovf = 1'b0;
            exp_q.delete();
        end else begin
            m_groups = (occ + L - 1) / L;
            m_rem    = occ - (m_groups - 1) * L;
            m_xf     = (occ > 0) && out_ready;
            m_pop    = m_xf && (m_rem == 1);
            m_acc    = in_valid && ((m_groups < DEPTH) || m_pop);
            if (m_xf) occ--;
            if (m_acc) begin
                occ += L;
                for (int i = 0; i < L; i++) exp_q.push_back('{in_y[i], (i == L - 1)});
            end else if (in_valid) begin
                ovf = 1'b1;
            end
        end
    end

    // Monitor: compares presented state and the head sample each cycle, pops on transfer
    always @(negedge clk) begin
        if (!rst) begin
            mon_groups = (occ + L - 1) / L;
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            chk("level", 64'(level), 64'(mon_groups));
            chk("full", 64'(full), 64'(mon_groups == DEPTH));
            chk("overflow", 64'(overflow), 64'(ovf));
            if (exp_q.size() != 0) begin
                chk("out_y", 64'(out_y), 64'(exp_q[0].d));
                chk("out_last", 64'(out_last), 64'(exp_q[0].last));
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("out_y_idle", 64'(out_y), 64'd0);
                chk("out_last_idle", 64'(out_last), 64'd0);
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit rdy, input bit cl);
        in_valid  = v;
        in_y[0]   = a;
        in_y[1]   = b;
        in_y[2]   = c;
        out_ready = rdy;
        clr       = cl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, rdy, 1'b0);
    endtask

    task automatic chk_zero_state(string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_y"}, 64'(out_y), 64'd0);
        chk({tag, "_out_last"}, 64'(out_last), 64'd0);
        chk({tag, "_level"}, 64'(level), 64'd0);
        chk({tag, "_full"}, 64'(full), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        logic [8:0] rp;
        for (int i = 0; i < L; i++) in_y[i] = '0;
        #1;
        chk_zero_state("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // single group with extreme Q31 values
        step(1'b1, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
        idle(4, 1'b1);

        // backpressure pattern 1,0,0,1,1,0,1,1,1
        rp = 9'b100110111;
        step(1'b1, 32'd1, 32'd2, 32'd3, rp[8], 1'b0);
        step(1'b1, 32'd4, 32'd5, 32'd6, rp[7], 1'b0);
        for (int i = 6; i >= 0; i--) step(1'b0, '0, '0, '0, rp[i], 1'b0);
        idle(4, 1'b1);

        // fill to DEPTH and drop the fifth group
        for (int g = 0; g < 5; g++) step(1'b1, 32'(100 + 3*g), 32'(101 + 3*g), 32'(102 + 3*g), 1'b0, 1'b0);
        idle(14, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);

        // full FIFO, head on its final lane, push lands together with the pop
        for (int g = 0; g < 4; g++) step(1'b1, 32'(200 + 3*g), 32'(201 + 3*g), 32'(202 + 3*g), 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b1, 32'd7, 32'd8, 32'd9, 1'b1, 1'b0);
        idle(14, 1'b1);

        // asynchronous reset after lane 1 of a group has been consumed
        step(1'b1, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0);
        idle(2, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero_state("midreset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(1'b1, 32'd10, 32'd11, 32'd12, 1'b1, 1'b0);
        idle(4, 1'b1);

        // clr beats a simultaneous push while overflow is set
        for (int g = 0; g < 5; g++) step(1'b1, 32'(300 + g), 32'(400 + g), 32'(500 + g), 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 1'b0, 1'b1);
        idle(4, 1'b1);

        // randomized traffic with occasional clr
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 2) == 0), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
        end
        idle(20, 1'b1);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fir_lane_serializer.md
# fir_lane_serializer

Downstream companion to the L-lane parallel FIR cores. Each valid cycle it captures one group of L adjacent Q31 outputs (y[Lk] … y[Lk+L-1]), buffers whole groups in a small FIFO, and emits them as a single-sample stream with a valid/ready handshake in time order. The FIR cores cannot be stalled, so the block flags dropped groups rather than back-pressuring.

## Interface
- L, 3, lanes per group (legal 1..4; 2 and 3 match the parallel FIR cores)
- DEPTH, 4, FIFO depth in groups (power of two, ≥2)
- W, 32, sample width (Q31 two's complement when W=32)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear: empties FIFO, zeroes lane counter, clears overflow
- in_valid  in  1  group present on in_y this cycle
- in_y  in  L×W (array [0:L-1])  in_y[0] oldest sample (y1), in_y[L-1] newest (yL)
- out_valid  out  1  out_y holds a valid sample
- out_ready  in  1  consumer accepts out_y this cycle
- out_y  out  W  current sample
- out_last  out  1  out_y is lane L-1 of its group
- level  out  $clog2(DEPTH+1)  groups currently stored, including a partly drained head
- full  out  1  level == DEPTH
- overflow  out  1  sticky: a group was dropped

## Operation
- Storage: DEPTH×L×W register array, write pointer, read pointer, level counter, lane counter lane ∈ [0, L-1].
- Push: on in_valid, the group is written at the write pointer when not full, or when full and a pop occurs in the same cycle (the final lane of the head is accepted). Otherwise the group is discarded whole and overflow is set to 1.
- Output: out_valid = (level != 0). out_y = head[lane] while valid; 0 while empty. out_last = out_valid && lane == L-1.
- Transfer: out_valid && out_ready. lane increments on each transfer. On a transfer with lane == L-1, lane wraps to 0, the read pointer advances (mod DEPTH), and the head is popped.
- Level: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Pointers wrap mod DEPTH.
- Data passes through bit-exact. No rounding, saturation or reordering within a group.
- clr: has priority over a push and a transfer in the same cycle. The group presented that cycle is not stored and overflow reads 0 next cycle.
- L=1 degenerates to a plain FIFO with out_last tied to out_valid.

## Timing
- Reset, asynchronous and any time (including mid-group): level=0, lane=0, pointers=0, out_valid=0, out_y=0, out_last=0, full=0, overflow=0. Stored data is lost.
- Latency: a group pushed at edge k drives out_valid=1 with out_y=in_y[0] in the cycle after edge k. There is no combinational path from in_* to out_*.
- out_ready held high: sample j of a group appears at edge k+j and the group is fully drained after L cycles. Sustained input must average ≤1 group per L cycles, or overflow occurs.
- out_y, out_last and out_valid are stable while out_valid=1 and out_ready=0. The consumer may toggle out_ready freely, and out_valid does not depend on out_ready.
- full and level reflect register state after the last edge. A push and a pop on the same edge leave full unchanged.
- overflow rises on the edge after the drop and holds until rst or clr.

## Test plan
- Single group, L=3: push {0x00000001, 0x7FFFFFFF, 0x80000000} with out_ready=1. Required: out_y sequence 1, 0x7FFFFFFF, 0x80000000 on the three cycles after the push; out_last only on the third; out_valid=0 afterwards; level 1→1→1→0.
- Backpressure: push two groups {1,2,3} and {4,5,6}. Toggle out_ready 1,0,0,1,1,0,1,1,1. Required: stream 1..6 in order, no duplicates or skips, out_y held during ready=0.
- Fill/overflow, DEPTH=4: out_ready=0 and push 5 groups. Required: full=1 after the 4th push; 5th group dropped; overflow=1; later draining yields exactly the first 4 groups (12 samples).
- Full with simultaneous pop: FIFO full, head at lane 2, out_ready=1, in_valid=1 with {7,8,9}. Required: accepted, overflow stays 0, level stays 4, {7,8,9} emitted last.
- Reset mid-group: assert rst asynchronously after lane 1 of a group is consumed. Required: out_valid, out_y, level, overflow at 0 immediately. A following push {10,11,12} emits starting at 10 (lane restarts at 0).
- clr vs push: clr=1 and in_valid=1 in the same cycle while overflow=1. Required: next cycle level=0, overflow=0, out_valid=0, and the group is not emitted.
